// File: rtl/run_ctrl_pkg.sv
// Shared types and default constants for the run_ctrl sequencer/arbiter.
package run_ctrl_pkg;

  // Sequencer states; FINISH is the post-run state that owns dmem for readback.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCESS = 3'd1,
    PRIME  = 3'd2,
    RUN    = 3'd3,
    FINISH = 3'd4
  } state_t;

  localparam int DEF_DW         = 32;
  localparam int DEF_MAX_CYCLES = 65535;
  localparam int DEF_CW         = 16;

endpackage

// File: rtl/run_ctrl_cycle_counter.sv
// RUN-cycle counter: synchronous clear, enable, saturating count and a
// terminal flag that marks the last cycle of the budget.
module cycle_counter
  import run_ctrl_pkg::*;
#(
  parameter int MAX_CYCLES = DEF_MAX_CYCLES,
  parameter int CW         = DEF_CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          enable,
  output logic [CW-1:0] count,
  output logic          terminal
);

  localparam logic [CW-1:0] TERM = CW'(MAX_CYCLES - 1);

  // Count enabled cycles; hold at all-ones so the value can never wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  // Terminal when the current cycle is the last one the budget allows.
  always_comb begin
    terminal = (count == TERM);
  end

endmodule

// File: rtl/run_ctrl.sv
// Sequencer and dmem arbiter for the RSA pipeline CPU: host loads operands
// while the CPU is held in reset, the CPU runs until its zero flag or the
// cycle budget, then dmem is handed back to the host for readback.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int DW         = DEF_DW,
  parameter int MAX_CYCLES = DEF_MAX_CYCLES,
  parameter int CW         = DEF_CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          host_go,
  input  logic          host_we,
  input  logic          host_re,
  input  logic [DW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic [DW-1:0] host_rdata,
  output logic          host_ack,
  input  logic          cpu_memwrite,
  input  logic [DW-1:0] cpu_adr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_reset,
  output logic          cpu_start,
  input  logic          cpu_done,
  output logic          mem_we,
  output logic [DW-1:0] mem_adr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic [CW-1:0] cycles
);

  state_t        state;
  state_t        state_next;
  state_t        ret_state;
  logic          cap_load;
  logic          cap_we;
  logic [DW-1:0] cap_adr;
  logic [DW-1:0] cap_wdata;
  logic          cnt_clear;
  logic          cnt_en;
  logic          cnt_term;
  logic          run_end;
  logic          run_timeout;

  cycle_counter #(
    .MAX_CYCLES(MAX_CYCLES),
    .CW        (CW)
  ) u_cycle_counter (
    .clk     (clk),
    .reset   (reset),
    .clear   (cnt_clear),
    .enable  (cnt_en),
    .count   (cycles),
    .terminal(cnt_term)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode plus the strobes that drive capture, counter and status.
  always_comb begin
    state_next  = state;
    cap_load    = 1'b0;
    cnt_clear   = 1'b0;
    cnt_en      = 1'b0;
    run_end     = 1'b0;
    run_timeout = 1'b0;
    unique case (state)
      IDLE, FINISH: begin
        // go wins; a same-cycle host access is dropped without an ack
        if (host_go) begin
          state_next = PRIME;
        end else if (host_we || host_re) begin
          state_next = ACCESS;
          cap_load   = 1'b1;
        end
      end
      ACCESS: begin
        state_next = ret_state;
      end
      PRIME: begin
        state_next = RUN;
        cnt_clear  = 1'b1;
      end
      RUN: begin
        cnt_en = 1'b1;
        // the CPU's own completion outranks budget exhaustion
        if (cpu_done) begin
          state_next = FINISH;
          run_end    = 1'b1;
        end else if (cnt_term) begin
          state_next  = FINISH;
          run_end     = 1'b1;
          run_timeout = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Capture the host request and remember which idle state to return to.
  always_ff @(posedge clk) begin
    if (reset) begin
      ret_state <= IDLE;
      cap_we    <= 1'b0;
      cap_adr   <= '0;
      cap_wdata <= '0;
    end else if (cap_load) begin
      ret_state <= state;
      cap_we    <= host_we;
      cap_adr   <= host_addr;
      cap_wdata <= host_wdata;
    end
  end

  // Sticky run status: cleared when a run is primed, set when it ends.
  always_ff @(posedge clk) begin
    if (reset) begin
      done    <= 1'b0;
      timeout <= 1'b0;
    end else if (state == PRIME) begin
      done    <= 1'b0;
      timeout <= 1'b0;
    end else if (run_end) begin
      done    <= 1'b1;
      timeout <= run_timeout;
    end
  end

  // Host completion: one-cycle ack after ACCESS, read data captured on reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      host_ack   <= 1'b0;
      host_rdata <= '0;
    end else begin
      host_ack <= (state == ACCESS);
      if ((state == ACCESS) && !cap_we) begin
        host_rdata <= mem_rdata;
      end
    end
  end

  // dmem port mux: CPU owns it in RUN, otherwise the host capture registers.
  always_comb begin
    mem_we    = 1'b0;
    mem_adr   = cap_adr;
    mem_wdata = cap_wdata;
    if (state == RUN) begin
      mem_we    = cpu_memwrite;
      mem_adr   = cpu_adr;
      mem_wdata = cpu_wdata;
    end else if (state == ACCESS) begin
      mem_we = cap_we;
    end
  end

  // CPU control and status flags; start is RUN with a freshly cleared counter.
  always_comb begin
    cpu_rdata = mem_rdata;
    cpu_reset = (state != RUN);
    cpu_start = (state == RUN) && (cycles == '0);
    busy      = (state == PRIME) || (state == RUN);
  end

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl with a small dmem model, a stub CPU driven from
// the stimulus, and a scoreboard of expected host read data checked on ack.
module tb_run_ctrl;

  localparam int DW = 32;
  localparam int CW = 16;
  localparam int MC = 8;

  logic          clk;
  logic          reset;
  logic          host_go;
  logic          host_we;
  logic          host_re;
  logic [DW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic [DW-1:0] host_rdata;
  logic          host_ack;
  logic          cpu_memwrite;
  logic [DW-1:0] cpu_adr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_reset;
  logic          cpu_start;
  logic          cpu_done;
  logic          mem_we;
  logic [DW-1:0] mem_adr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;
  logic          done;
  logic          timeout;
  logic [CW-1:0] cycles;

  logic [DW-1:0] mem [0:255];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] model_rdata;
  int            total;
  int            bad;

  run_ctrl #(
    .DW        (DW),
    .MAX_CYCLES(MC),
    .CW        (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .host_go     (host_go),
    .host_we     (host_we),
    .host_re     (host_re),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_rdata  (host_rdata),
    .host_ack    (host_ack),
    .cpu_memwrite(cpu_memwrite),
    .cpu_adr     (cpu_adr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_reset   (cpu_reset),
    .cpu_start   (cpu_start),
    .cpu_done    (cpu_done),
    .mem_we      (mem_we),
    .mem_adr     (mem_adr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .busy        (busy),
    .done        (done),
    .timeout     (timeout),
    .cycles      (cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dmem model: synchronous write, combinational read.
  always @(posedge clk) begin
    if (mem_we && (mem_adr < 256)) mem[mem_adr[7:0]] <= mem_wdata;
  end
  assign mem_rdata = (mem_adr < 256) ? mem[mem_adr[7:0]] : '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every ack must match a queued request; compare captured read data.
  always @(negedge clk) begin
    if (host_ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_ack", 32'(host_ack), 32'(1'b0));
      end else begin
        chk("sb_rdata", host_rdata, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    model_rdata = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    reset = 1'b1; host_go = 1'b0; host_we = 1'b0; host_re = 1'b0;
    host_addr = '0; host_wdata = '0;
    cpu_memwrite = 1'b0; cpu_adr = '0; cpu_wdata = '0; cpu_done = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_cpu_reset", 32'(cpu_reset), 32'(1'b1));
    chk("rst_cpu_start", 32'(cpu_start), 32'(1'b0));
    chk("rst_ack",       32'(host_ack),  32'(1'b0));
    chk("rst_rdata",     host_rdata,     32'h0);
    chk("rst_done",      32'(done),      32'(1'b0));
    chk("rst_timeout",   32'(timeout),   32'(1'b0));
    chk("rst_cycles",    32'(cycles),    32'h0);
    chk("rst_busy",      32'(busy),      32'(1'b0));
    chk("rst_mem_we",    32'(mem_we),    32'(1'b0));

    // Host write 0xA5 to 0x10, then read back from the ack cycle.
    host_we = 1'b1; host_addr = 32'h10; host_wdata = 32'hA5;
    exp_q.push_back(model_rdata);
    tick();
    host_we = 1'b0;
    #1;
    chk("acc_mem_we",  32'(mem_we), 32'(1'b1));
    chk("acc_mem_adr", mem_adr,     32'h10);
    chk("acc_no_ack",  32'(host_ack), 32'(1'b0));
    tick();
    chk("wr_ack",      32'(host_ack), 32'(1'b1));
    chk("wr_mem",      mem[8'h10],    32'hA5);
    host_re = 1'b1; host_addr = 32'h10;
    model_rdata = 32'hA5;
    exp_q.push_back(model_rdata);
    tick();
    host_re = 1'b0;
    tick();
    chk("rd_ack",      32'(host_ack), 32'(1'b1));
    chk("rd_rdata",    host_rdata,    32'hA5);
    tick();
    chk("ack_one_cyc", 32'(host_ack), 32'(1'b0));

    // Run to done on the 5th RUN cycle.
    host_go = 1'b1;
    tick();
    host_go = 1'b0;
    chk("prime_busy",  32'(busy),      32'(1'b1));
    chk("prime_creset",32'(cpu_reset), 32'(1'b1));
    chk("prime_start", 32'(cpu_start), 32'(1'b0));
    tick();
    for (int k = 1; k <= 5; k++) begin
      chk("run_start",  32'(cpu_start), 32'(k == 1));
      chk("run_creset", 32'(cpu_reset), 32'(1'b0));
      if (k == 5) cpu_done = 1'b1;
      tick();
    end
    cpu_done = 1'b0;
    chk("fin_done",    32'(done),      32'(1'b1));
    chk("fin_timeout", 32'(timeout),   32'(1'b0));
    chk("fin_cycles",  32'(cycles),    32'd5);
    chk("fin_creset",  32'(cpu_reset), 32'(1'b1));
    chk("fin_busy",    32'(busy),      32'(1'b0));

    // Timeout after MC RUN cycles; go from FINISH clears status.
    host_go = 1'b1;
    tick();
    host_go = 1'b0;
    tick();
    chk("go2_done",    32'(done),    32'(1'b0));
    chk("go2_timeout", 32'(timeout), 32'(1'b0));
    chk("go2_cycles",  32'(cycles),  32'h0);
    for (int k = 1; k <= MC; k++) begin
      if (k == MC) chk("to_last_busy", 32'(busy), 32'(1'b1));
      tick();
    end
    chk("to_done",    32'(done),    32'(1'b1));
    chk("to_timeout", 32'(timeout), 32'(1'b1));
    chk("to_cycles",  32'(cycles),  32'(MC));

    // Done coincides with budget exhaustion: done wins.
    host_go = 1'b1;
    tick();
    host_go = 1'b0;
    tick();
    for (int k = 1; k <= MC; k++) begin
      if (k == MC) cpu_done = 1'b1;
      tick();
    end
    cpu_done = 1'b0;
    chk("tie_done",    32'(done),    32'(1'b1));
    chk("tie_timeout", 32'(timeout), 32'(1'b0));
    chk("tie_cycles",  32'(cycles),  32'(MC));

    // Arbitration: CPU write in RUN, concurrent host write ignored.
    host_go = 1'b1;
    tick();
    host_go = 1'b0;
    tick();
    cpu_memwrite = 1'b1; cpu_adr = 32'h20; cpu_wdata = 32'h1234;
    host_we = 1'b1; host_addr = 32'h30; host_wdata = 32'hDEAD;
    #1;
    chk("arb_mem_we",    32'(mem_we), 32'(1'b1));
    chk("arb_mem_adr",   mem_adr,     32'h20);
    chk("arb_mem_wdata", mem_wdata,   32'h1234);
    tick();
    cpu_memwrite = 1'b0; host_we = 1'b0;
    #1;
    chk("arb_cpu_rdata", cpu_rdata, 32'h1234);
    cpu_done = 1'b1;
    tick();
    cpu_done = 1'b0;
    chk("arb_host_mem", mem[8'h30], 32'h0);
    cpu_memwrite = 1'b1;
    #1;
    chk("fin_memwr_ign", 32'(mem_we), 32'(1'b0));
    cpu_memwrite = 1'b0;
    host_re = 1'b1; host_addr = 32'h20;
    model_rdata = 32'h1234;
    exp_q.push_back(model_rdata);
    tick();
    host_re = 1'b0;
    tick();
    chk("fin_rd_rdata", host_rdata, 32'h1234);
    chk("fin_ret_done", 32'(done),  32'(1'b1));
    chk("fin_ret_busy", 32'(busy),  32'(1'b0));

    // go and we in the same cycle: go wins, write dropped.
    host_go = 1'b1; host_we = 1'b1; host_addr = 32'h40; host_wdata = 32'h77;
    tick();
    host_go = 1'b0; host_we = 1'b0;
    chk("pri_busy", 32'(busy),     32'(1'b1));
    chk("pri_ack",  32'(host_ack), 32'(1'b0));
    tick();
    chk("pri_mem",  mem[8'h40],    32'h0);
    chk("pri_done", 32'(done),     32'(1'b0));
    chk("pri_cyc",  32'(cycles),   32'h0);

    // Reset in RUN cycle 3.
    tick(); tick();
    chk("mid_cycles", 32'(cycles), 32'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cpu_memwrite = 1'b1;
    #1;
    chk("mr_busy",   32'(busy),      32'(1'b0));
    chk("mr_creset", 32'(cpu_reset), 32'(1'b1));
    chk("mr_done",   32'(done),      32'(1'b0));
    chk("mr_cycles", 32'(cycles),    32'h0);
    chk("mr_mem_we", 32'(mem_we),    32'(1'b0));
    cpu_memwrite = 1'b0;

    // Reset during a write ACCESS: write still lands, no ack.
    host_we = 1'b1; host_addr = 32'h50; host_wdata = 32'h99;
    tick();
    host_we = 1'b0;
    reset = 1'b1;
    #1;
    chk("ra_mem_we", 32'(mem_we), 32'(1'b1));
    tick();
    reset = 1'b0;
    chk("ra_mem",  mem[8'h50],    32'h99);
    chk("ra_ack",  32'(host_ack), 32'(1'b0));
    tick(); tick();
    chk("sb_drain", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
